// File: rtl/display_varredura_n_if.sv
// display_varredura_n_if: inputs and pin-level outputs of the multiplexed 7-segment driver.
interface display_varredura_n_if #(
    parameter int N_DIGITS = 4
);
    localparam int SW = $clog2(N_DIGITS);
    logic                    ligado;
    logic [4*N_DIGITS-1:0]   digitos;
    logic [N_DIGITS-1:0]     pontos;
    logic [N_DIGITS-1:0]     piscar;
    logic                    suprimir_zeros;
    logic [7:0]              segmentos;
    logic [N_DIGITS-1:0]     anodos;
    logic [SW-1:0]           digito_atual;
    logic                    fim_varredura;
    modport master (
        output ligado, digitos, pontos, piscar, suprimir_zeros,
        input  segmentos, anodos, digito_atual, fim_varredura
    );
    modport slave (
        input  ligado, digitos, pontos, piscar, suprimir_zeros,
        output segmentos, anodos, digito_atual, fim_varredura
    );
endinterface

// File: rtl/display_varredura_n.sv
// display_varredura_n: self-timed multiplexed 7-segment scan with dead time,
// leading-zero suppression, per-digit blink and decimal point.
module display_varredura_n #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    display_varredura_n_if.slave      bus
);
    localparam int SW = $clog2(N_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam bit AL = ACTIVE_LOW != 0;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [FW-1:0]       frm_q, frm_d;
    logic                fase_q, fase_d;
    logic                fim_q, fim_d;
    logic [7:0]          seg_q, seg_d, seg_l;
    logic [N_DIGITS-1:0] an_q, an_d, an_l;
    logic [N_DIGITS-1:0] lz;
    logic [3:0]          dig;
    logic [6:0]          dec;
    logic                wrap, frame_end, last_frame, dark, off;

    always_comb begin
        wrap       = cnt_q == CW'(REFRESH_DIV - 1);
        frame_end  = wrap && sel_q == SW'(N_DIGITS - 1);
        last_frame = frm_q == FW'(BLINK_FRAMES - 1);
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        sel_d      = frame_end ? '0 : wrap ? sel_q + 1'b1 : sel_q;
        frm_d      = frame_end ? (last_frame ? '0 : frm_q + 1'b1) : frm_q;
        fase_d     = fase_q ^ (frame_end && last_frame);
        fim_d      = frame_end;
    end

    // lz[i]: digit i and every digit above it are zero; digit 0 is never suppressed
    always_comb begin
        lz = '0;
        lz[N_DIGITS-1] = bus.digitos[4*N_DIGITS-1 -: 4] == 4'd0;
        for (int i = N_DIGITS - 2; i >= 0; i--)
            lz[i] = lz[i+1] && bus.digitos[4*i +: 4] == 4'd0;
        lz[0] = 1'b0;
    end

    always_comb begin
        dig = bus.digitos[{sel_q, 2'b00} +: 4];
        case (dig)
            4'd0:    dec = 7'b1111110;
            4'd1:    dec = 7'b0110000;
            4'd2:    dec = 7'b1101101;
            4'd3:    dec = 7'b1111001;
            4'd4:    dec = 7'b0110011;
            4'd5:    dec = 7'b1011011;
            4'd6:    dec = 7'b1011111;
            4'd7:    dec = 7'b1110000;
            4'd8:    dec = 7'b1111111;
            4'd9:    dec = 7'b1111011;
            4'd15:   dec = 7'b0000000;
            default: dec = 7'b0000001;
        endcase
    end

    // dead time slot (cnt==0) and display-off override blink, suppression and decode
    always_comb begin
        dark  = cnt_q == '0 || !bus.ligado;
        off   = dark || (bus.piscar[sel_q] && fase_q);
        seg_l = off ? 8'd0 : {(bus.suprimir_zeros && lz[sel_q]) ? 7'd0 : dec, bus.pontos[sel_q]};
        an_l  = dark ? '0 : N_DIGITS'(1) << sel_q;
        seg_d = seg_l ^ {8{AL}};
        an_d  = an_l ^ {N_DIGITS{AL}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            frm_q  <= '0;
            fase_q <= 1'b0;
            fim_q  <= 1'b0;
            seg_q  <= {8{AL}};
            an_q   <= {N_DIGITS{AL}};
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            frm_q  <= frm_d;
            fase_q <= fase_d;
            fim_q  <= fim_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign bus.segmentos     = seg_q;
    assign bus.anodos        = an_q;
    assign bus.digito_atual  = sel_q;
    assign bus.fim_varredura = fim_q;
endmodule

// File: tb/tb_display_varredura_n.sv
// tb_display_varredura_n: table vectors, hand-written corner sequences and a
// randomized run against a cycle-count based reference model.
module tb_display_varredura_n;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    display_varredura_n_if #(.N_DIGITS(4)) bus();

    display_varredura_n #(
        .N_DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int s     = 0;

    logic [6:0] segtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h00};

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  pt;
        logic        sz;
        int          idx;
        logic [7:0]  seg;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, s);
        end
    endtask

    // pins {segmentos, anodos} produced from the state at scan step st since reset
    function automatic logic [11:0] ref_pins(input int st);
        int cnt, sel, fase;
        logic [15:0] above;
        logic [7:0] seg;
        logic [3:0] an;
        cnt  = st % 4;
        sel  = (st / 4) % 4;
        fase = (st / 16 / 2) % 2;
        if (!bus.ligado || cnt == 0) return {8'hFF, 4'hF};
        above = bus.digitos >> (4 * sel);
        if (bus.piscar[sel] && fase == 1) seg = 8'h00;
        else seg = {(bus.suprimir_zeros && sel > 0 && above == 16'h0) ? 7'h00 : segtab[above[3:0]],
                    bus.pontos[sel]};
        an = 4'b0001 << sel;
        return {~seg, ~an};
    endfunction

    task automatic chk_model();
        logic [11:0] e;
        logic [1:0] esel;
        logic efim;
        e    = (s == 0) ? {8'hFF, 4'hF} : ref_pins(s - 1);
        esel = 2'((s / 4) % 4);
        efim = s > 0 && s % 16 == 0;
        chk("model_seg", bus.segmentos, e[11:4]);
        chk("model_an", bus.anodos, e[3:0]);
        chk("model_sel", bus.digito_atual, esel);
        chk("model_fim", bus.fim_varredura, efim);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        s = reset ? 0 : s + 1;
        chk_model();
    endtask

    task automatic post_release(input string nm);
        reset = 1'b0;
        step(); chk({nm, "_dark0_seg"}, bus.segmentos, 8'hFF); chk({nm, "_dark0_an"}, bus.anodos, 4'hF);
        repeat (3) begin step(); chk({nm, "_d0_an"}, bus.anodos, 4'b1110); end
        step(); chk({nm, "_dead_an"}, bus.anodos, 4'hF);
        step(); chk({nm, "_d1_an"}, bus.anodos, 4'b1101);
    endtask

    initial begin
        logic [3:0] ea;
        int lit, drk, k;
        vt[0]  = '{16'h1234, 4'b0010, 1'b0, 0, 8'h99};
        vt[1]  = '{16'h1234, 4'b0010, 1'b0, 1, 8'h0C};
        vt[2]  = '{16'h1234, 4'b0010, 1'b0, 2, 8'h25};
        vt[3]  = '{16'h1234, 4'b0010, 1'b0, 3, 8'h9F};
        vt[4]  = '{16'h0007, 4'b0000, 1'b1, 3, 8'hFF};
        vt[5]  = '{16'h0007, 4'b0000, 1'b1, 2, 8'hFF};
        vt[6]  = '{16'h0007, 4'b0000, 1'b1, 1, 8'hFF};
        vt[7]  = '{16'h0007, 4'b0000, 1'b1, 0, 8'h1F};
        vt[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 8'h03};
        vt[9]  = '{16'h0300, 4'b0000, 1'b1, 3, 8'hFF};
        vt[10] = '{16'h0300, 4'b0000, 1'b1, 2, 8'h0D};
        vt[11] = '{16'h0300, 4'b0000, 1'b1, 1, 8'h03};
        vt[12] = '{16'h0300, 4'b0000, 1'b1, 0, 8'h03};
        vt[13] = '{16'h0000, 4'b0010, 1'b1, 1, 8'hFE};
        vt[14] = '{16'h000A, 4'b0000, 1'b0, 0, 8'hFD};
        vt[15] = '{16'h000F, 4'b0000, 1'b0, 0, 8'hFF};

        bus.ligado = 1'b1; bus.digitos = 16'h1234; bus.pontos = 4'b0000;
        bus.piscar = 4'b0000; bus.suprimir_zeros = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("rst_seg", bus.segmentos, 8'hFF);
            chk("rst_an", bus.anodos, 4'hF);
        end
        post_release("rel");

        for (int v = 0; v < 16; v++) begin
            bus.digitos = vt[v].dig; bus.pontos = vt[v].pt; bus.suprimir_zeros = vt[v].sz;
            ea = ~(4'b0001 << vt[v].idx);
            for (k = 0; k < 40; k++) begin
                step();
                if (bus.anodos == ea) break;
            end
            chk("vec_an", bus.anodos, ea);
            chk("vec_seg", bus.segmentos, vt[v].seg);
        end

        bus.suprimir_zeros = 1'b0; bus.pontos = 4'b0000;
        bus.digitos = 16'h0008; bus.piscar = 4'b0001;
        lit = 0; drk = 0;
        repeat (64) begin
            step();
            if (bus.anodos == 4'b1110) begin
                if (bus.segmentos == 8'h01) lit++;
                if (bus.segmentos == 8'hFF) drk++;
            end
        end
        chk("blink_lit_seen", lit > 0, 1'b1);
        chk("blink_dark_seen", drk > 0, 1'b1);

        for (k = 0; k < 8 && s % 4 != 2; k++) step();
        bus.ligado = 1'b0;
        step();
        chk("off_seg", bus.segmentos, 8'hFF);
        chk("off_an", bus.anodos, 4'hF);
        repeat (20) step();
        bus.ligado = 1'b1;
        repeat (20) step();

        for (k = 0; k < 80 && s % 64 != 43; k++) step();
        chk("reach_sel2_cnt3_fase1", s % 64, 43);
        reset = 1'b1;
        step();
        chk("mid_rst_sel", bus.digito_atual, 2'd0);
        chk("mid_rst_seg", bus.segmentos, 8'hFF);
        chk("mid_rst_an", bus.anodos, 4'hF);
        chk("mid_rst_fim", bus.fim_varredura, 1'b0);
        post_release("mid");
        repeat (20) step();

        repeat (900) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int n = 0; n < 4; n++)
                    bus.digitos[4*n +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
                bus.pontos = 4'($urandom_range(0, 15));
                bus.piscar = 4'($urandom_range(0, 15));
                bus.suprimir_zeros = 1'($urandom_range(0, 1));
            end
            bus.ligado = $urandom_range(0, 5) != 0;
            reset = $urandom_range(0, 149) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_varredura_n.md
Name: display_varredura_n

Overview:
Parametrised, self-timed multiplexed 7-segment display driver for the CPLD board. It generalises the fixed 4-digit combinational display path in four ways. It generates its own refresh scan from the system clock with a per-digit dead time. The digit count is parametrised. It adds leading-zero suppression, per-digit blink and per-digit decimal point. It sits between the counter/BCD logic (duzias/rolhas digits) and the board's shared segment and digit-select pins.

Parameters:
N_DIGITS, 4, number of digits scanned (≥2)
REFRESH_DIV, 50000, clock cycles per digit slot (≥2)
BLINK_FRAMES, 64, full scan frames per blink half-period (≥1)
ACTIVE_LOW, 1, 1 = segment and digit-select pins active-low (board default); 0 = active-high

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ligado  in  1  1 = display on; 0 = all digits dark
digitos  in  4*N_DIGITS  BCD digit i = digitos[4i+3:4i]; digit 0 rightmost, digit N_DIGITS-1 leftmost
pontos  in  N_DIGITS  dp enable per digit
piscar  in  N_DIGITS  blink enable per digit
suprimir_zeros  in  1  leading-zero suppression enable
segmentos  out  8  {a,b,c,d,e,f,g,dp}
anodos  out  N_DIGITS  digit select, bit i drives digit i
digito_atual  out  clog2(N_DIGITS)  index of digit currently scanned
fim_varredura  out  1  one-cycle pulse per completed frame

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, sel (= digito_atual) increments. sel N_DIGITS-1 wraps to 0.
- fim_varredura = 1 for exactly the one cycle in which sel becomes 0 by wrap. It is never asserted on reset.
- Blink phase fase toggles after every BLINK_FRAMES fim_varredura pulses. The frame counter wraps.
- segmentos and anodos are registered. They reflect (sel, cnt, inputs) sampled on the previous clock, so latency is 1 cycle. Inputs are not latched; a change shows on the next clock.
- Dead time: when cnt==0, all anodos are inactive and segmentos are all off (anti-ghosting). For cnt 1..REFRESH_DIV-1, only anodos[sel] is active.
- Decode (logical, 1 = lit, order a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Codes 10..14 = dash (0000001). Code 15 = blank.
- dp is lit when pontos[sel]=1.
- Leading-zero suppression applies when suprimir_zeros=1. Digit i (i≥1) is blanked when digit i and every digit above it are 0. Digit 0 is never suppressed. dp of a suppressed digit still follows pontos.
- Blink: when piscar[sel]=1 and fase=1, a–g and dp are off. The anode still follows the scan.
- ligado=0: all segments off and all anodos inactive from the next clock. cnt, sel, fase and fim_varredura keep running.
- Priority (highest first): dead time / ligado=0, then blink, then suppression, then decode.
- ACTIVE_LOW=1 inverts both segmentos and anodos at the output register. Fully dark is segmentos=8'hFF, anodos all 1.
- Reset, including mid-slot: cnt=0, sel=0, frame counter=0, fase=0, fim_varredura=0, segmentos all off, anodos all inactive (ACTIVE_LOW=1: 8'hFF / all 1).
- After reset release: 1 dark cycle (cnt=0), then digit 0 for REFRESH_DIV-1 cycles.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.

1. Reset: hold reset 3 clocks with ligado=1 and digitos=16'h1234 -> segmentos=8'hFF and anodos=4'hF during reset and on the first clock after release. Then anodos=4'b1110 for 3 clocks, then 4'hF for 1 clock, then 4'b1101.
2. Scan/decode: digitos=16'h1234, pontos=4'b0010 -> digit0 segmentos=8'h99 ("4"). Digit1 = 8'h0C ("3" with dp). Digit2 = 8'h25 ("2"). Digit3 = 8'h9F ("1"). fim_varredura pulses every 16 clocks, coinciding with digito_atual going 3 to 0.
3. Suppression: suprimir_zeros=1, digitos=16'h0007 -> digits 3..1 show 8'hFF and digit0 shows 8'h1F. With digitos=16'h0000, digit0 shows 8'h03. With digitos=16'h0300, digit3 shows 8'hFF and digit0 shows 8'h03.
4. Blink: piscar=4'b0001, digitos=16'h0008 -> digit0 shows 8'h01 for 2 frames (32 clocks), then 8'hFF for 2 frames, alternating. The other digits are unaffected.
5. Enable: drop ligado mid-slot -> next clock segmentos=8'hFF and anodos=4'hF. fim_varredura cadence is unchanged. Restoring ligado resumes the scan at the current sel with no phase slip.
6. Mid-operation reset: assert reset at sel=2, cnt=3 -> next clock sel=0, cnt=0, fase=0 and outputs dark. Scenario 1's post-release sequence then repeats.
